// File: rtl/ai_cmd_encoder_pkg.sv
// ---------------------------------------------------------------------------
// ai_cmd_encoder_pkg
//   Shared definitions for the UART move-request initiator: protocol
//   constants, frame/reply lengths and the FSM state encoding.
// ---------------------------------------------------------------------------
package ai_cmd_encoder_pkg;

   localparam logic [7:0] CMD_MOVE = 8'h01;   // first byte of every frame
   localparam int         TX_BYTES = 10;      // CMD + COLOR + 8 payload bytes
   localparam int         RX_BYTES = 8;       // reply length
   localparam int         CNT_W    = 4;       // width of tx/rx byte counters

   // Counter values seen while the last byte of a phase is being handled.
   localparam logic [CNT_W-1:0] TX_LAST = CNT_W'(TX_BYTES - 1);
   localparam logic [CNT_W-1:0] RX_LAST = CNT_W'(RX_BYTES - 1);

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_LOAD      = 3'd1,
      ST_WAIT_IDLE = 3'd2,
      ST_WAIT_ACK  = 3'd3,
      ST_RECV      = 3'd4,
      ST_FIN       = 3'd5
   } state_e;

   // States in which the link is expected to make progress, so the
   // inactivity counter runs.
   function automatic logic is_timed(state_e s);
      return (s == ST_WAIT_IDLE) || (s == ST_WAIT_ACK) || (s == ST_RECV);
   endfunction

endpackage

// File: rtl/ai_cmd_timeout.sv
// ---------------------------------------------------------------------------
// ai_cmd_timeout
//   Inactivity counter with synchronous clear and a terminal-count flag.
//   The counter counts while en_i is high, saturates and never wraps.
//   tc_o flags the cycle in which the count would reach TIMEOUT_CYC-1, so
//   a registered reaction to it becomes visible TIMEOUT_CYC cycles after
//   the last clear.
// Ports
//   clk_i   clock
//   rst_ni  async active-low reset
//   clr_i   clear the count to 0 (wins over counting)
//   en_i    count enable
//   tc_o    terminal-count flag (combinational from count and enable)
// ---------------------------------------------------------------------------
module ai_cmd_timeout #(
   parameter int TIMEOUT_CYC = 27_000_000
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic clr_i,
   input  logic en_i,
   output logic tc_o
);

   localparam int               CNT_W  = $clog2(TIMEOUT_CYC);
   localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(TIMEOUT_CYC - 2);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   assign tc_o = en_i && (cnt_q == TC_VAL);

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i && !tc_o) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/ai_cmd_encoder.sv
// ---------------------------------------------------------------------------
// ai_cmd_encoder
//   Host-side initiator of the board's UART command protocol. On an accepted
//   iSTART it frames {CMD_MOVE, iCOLOR, iDATA} (10 bytes, MSB first), hands
//   the bytes one at a time to the UART transmitter using a Start/Done
//   handshake, then collects an 8-byte reply (MSB byte first) into oDATA.
//   Any stall in the link longer than TIMEOUT_CYC cycles aborts the
//   transaction with a oTIMEOUT pulse.
// Ports
//   iCLK, iRST_n         clock, async active-low reset
//   iSTART               one-cycle request, only honoured while idle
//   iCOLOR, iDATA        frame contents, captured on the accepted iSTART
//   oBUSY                transaction in flight
//   oDONE, oTIMEOUT      one-cycle completion / abort pulses
//   oDATA                last complete reply
//   oTXD_DATA, oTXD_Start  byte and strobe toward the transmitter
//   iTXD_Done            transmitter idle
//   iRXD_DATA, iRXD_Ready  received byte and its strobe
// ---------------------------------------------------------------------------
module ai_cmd_encoder
   import ai_cmd_encoder_pkg::*;
#(
   parameter int TIMEOUT_CYC = 27_000_000
) (
   input  logic        iCLK,
   input  logic        iRST_n,
   input  logic        iSTART,
   input  logic [7:0]  iCOLOR,
   input  logic [63:0] iDATA,
   output logic        oBUSY,
   output logic        oDONE,
   output logic        oTIMEOUT,
   output logic [63:0] oDATA,
   output logic [7:0]  oTXD_DATA,
   output logic        oTXD_Start,
   input  logic        iTXD_Done,
   input  logic [7:0]  iRXD_DATA,
   input  logic        iRXD_Ready
);

   state_e            state_q,    state_d;
   logic [79:0]       tx_shift_q, tx_shift_d;
   logic [63:0]       rx_shift_q, rx_shift_d;
   logic [CNT_W-1:0]  tx_cnt_q,   tx_cnt_d;
   logic [CNT_W-1:0]  rx_cnt_q,   rx_cnt_d;
   logic              busy_q,     busy_d;
   logic              done_q,     done_d;
   logic              tout_q,     tout_d;
   logic [63:0]       data_q,     data_d;
   logic [7:0]        txd_data_q, txd_data_d;
   logic              txd_start_q, txd_start_d;

   logic              rx_take;
   logic              tmo_clr;
   logic              tmo_tc;

   // The inactivity window restarts whenever the FSM makes progress:
   // any state change or any reply byte accepted.
   assign tmo_clr = (state_d != state_q) || rx_take;

   ai_cmd_timeout #(
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) u_timeout (
      .clk_i  (iCLK),
      .rst_ni (iRST_n),
      .clr_i  (tmo_clr),
      .en_i   (is_timed(state_q)),
      .tc_o   (tmo_tc)
   );

   // NOTE: every signal written here gets a default first, so no path
   // leaves one unassigned and no latch is inferred.
   always_comb begin
      state_d     = state_q;
      tx_shift_d  = tx_shift_q;
      rx_shift_d  = rx_shift_q;
      tx_cnt_d    = tx_cnt_q;
      rx_cnt_d    = rx_cnt_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
      tout_d      = 1'b0;
      data_d      = data_q;
      txd_data_d  = txd_data_q;
      txd_start_d = 1'b0;
      rx_take     = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (iSTART) begin
               tx_shift_d = {CMD_MOVE, iCOLOR, iDATA};
               tx_cnt_d   = '0;
               busy_d     = 1'b1;
               state_d    = ST_LOAD;
            end
         end

         ST_LOAD: begin
            state_d = ST_WAIT_IDLE;
         end

         ST_WAIT_IDLE: begin
            if (tmo_tc) begin
               tout_d  = 1'b1;
               busy_d  = 1'b0;
               state_d = ST_IDLE;
            end else if (iTXD_Done) begin
               txd_data_d  = tx_shift_q[79:72];
               txd_start_d = 1'b1;
               state_d     = ST_WAIT_ACK;
            end
         end

         // The transmitter drops Done once it has taken the byte; only then
         // is the next byte presented, so Start never hits a busy transmitter.
         ST_WAIT_ACK: begin
            if (tmo_tc) begin
               tout_d  = 1'b1;
               busy_d  = 1'b0;
               state_d = ST_IDLE;
            end else if (!iTXD_Done) begin
               tx_shift_d = {tx_shift_q[71:0], 8'h00};
               tx_cnt_d   = tx_cnt_q + CNT_W'(1);
               if (tx_cnt_q == TX_LAST) begin
                  rx_cnt_d = '0;
                  state_d  = ST_RECV;
               end else begin
                  state_d  = ST_WAIT_IDLE;
               end
            end
         end

         // Timeout is tested first so it wins over a byte arriving in the
         // same cycle. The completing byte loads oDATA and raises oDONE on
         // the same edge, so oDONE trails the last strobe by one cycle.
         ST_RECV: begin
            if (tmo_tc) begin
               tout_d  = 1'b1;
               busy_d  = 1'b0;
               state_d = ST_IDLE;
            end else if (iRXD_Ready) begin
               rx_take    = 1'b1;
               rx_shift_d = {rx_shift_q[55:0], iRXD_DATA};
               rx_cnt_d   = rx_cnt_q + CNT_W'(1);
               if (rx_cnt_q == RX_LAST) begin
                  data_d  = {rx_shift_q[55:0], iRXD_DATA};
                  done_d  = 1'b1;
                  busy_d  = 1'b0;
                  state_d = ST_FIN;
               end
            end
         end

         // One dead cycle alongside the oDONE pulse; iSTART is not sampled.
         ST_FIN: begin
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge iCLK or negedge iRST_n) begin
      if (!iRST_n) begin
         state_q     <= ST_IDLE;
         tx_shift_q  <= '0;
         rx_shift_q  <= '0;
         tx_cnt_q    <= '0;
         rx_cnt_q    <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         tout_q      <= 1'b0;
         data_q      <= '0;
         txd_data_q  <= '0;
         txd_start_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         tx_shift_q  <= tx_shift_d;
         rx_shift_q  <= rx_shift_d;
         tx_cnt_q    <= tx_cnt_d;
         rx_cnt_q    <= rx_cnt_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         tout_q      <= tout_d;
         data_q      <= data_d;
         txd_data_q  <= txd_data_d;
         txd_start_q <= txd_start_d;
      end
   end

   assign oBUSY      = busy_q;
   assign oDONE      = done_q;
   assign oTIMEOUT   = tout_q;
   assign oDATA      = data_q;
   assign oTXD_DATA  = txd_data_q;
   assign oTXD_Start = txd_start_q;

endmodule

// File: tb/tb_ai_cmd_encoder.sv
// ---------------------------------------------------------------------------
// tb_ai_cmd_encoder
//   Directed bench for ai_cmd_encoder with TIMEOUT_CYC=100. A small
//   transmitter model logs every byte strobed by the DUT and stays busy for
//   a few cycles per byte; replies are driven byte-wise on the RX side.
// ---------------------------------------------------------------------------
module tb_ai_cmd_encoder;

   logic        iCLK = 1'b0;
   logic        iRST_n = 1'b0;
   logic        iSTART = 1'b0;
   logic [7:0]  iCOLOR = '0;
   logic [63:0] iDATA = '0;
   logic        oBUSY, oDONE, oTIMEOUT;
   logic [63:0] oDATA;
   logic [7:0]  oTXD_DATA;
   logic        oTXD_Start;
   logic        tx_done = 1'b1;
   logic [7:0]  iRXD_DATA = '0;
   logic        iRXD_Ready = 1'b0;

   int          busy_left = 0;
   int          start_while_busy = 0;
   int          done_cnt = 0;
   int          tout_cnt = 0;
   logic [7:0]  tx_log[$];

   int          n_cmp = 0;
   int          n_err = 0;

   ai_cmd_encoder #(.TIMEOUT_CYC(100)) dut (
      .iCLK       (iCLK),
      .iRST_n     (iRST_n),
      .iSTART     (iSTART),
      .iCOLOR     (iCOLOR),
      .iDATA      (iDATA),
      .oBUSY      (oBUSY),
      .oDONE      (oDONE),
      .oTIMEOUT   (oTIMEOUT),
      .oDATA      (oDATA),
      .oTXD_DATA  (oTXD_DATA),
      .oTXD_Start (oTXD_Start),
      .iTXD_Done  (tx_done),
      .iRXD_DATA  (iRXD_DATA),
      .iRXD_Ready (iRXD_Ready)
   );

   always #5 iCLK = ~iCLK;

   // Transmitter model: takes a byte on Start, then busy for 3 cycles.
   // Pulse monitors count oDONE / oTIMEOUT cycles.
   always @(posedge iCLK) begin
      if (oTXD_Start) begin
         if (!tx_done) start_while_busy <= start_while_busy + 1;
         tx_log.push_back(oTXD_DATA);
         tx_done   <= 1'b0;
         busy_left <= 3;
      end else if (busy_left > 0) begin
         busy_left <= busy_left - 1;
         if (busy_left == 1) tx_done <= 1'b1;
      end
      if (oDONE)    done_cnt <= done_cnt + 1;
      if (oTIMEOUT) tout_cnt <= tout_cnt + 1;
   end

   task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // All stimulus tasks are entered and left on a falling edge.
   task automatic pulse_start(input logic [7:0] color, input logic [63:0] data);
      iSTART = 1'b1;
      iCOLOR = color;
      iDATA  = data;
      @(negedge iCLK);
      iSTART = 1'b0;
   endtask

   task automatic send_rx(input logic [7:0] b);
      iRXD_DATA  = b;
      iRXD_Ready = 1'b1;
      @(negedge iCLK);
      iRXD_Ready = 1'b0;
   endtask

   task automatic wait_tx(input int n);
      int waited = 0;
      while (tx_log.size() < n && waited < 400) begin
         @(negedge iCLK);
         waited++;
      end
      check($sformatf("tx_count_reached_%0d", n), 80'(tx_log.size()), 80'(n));
   endtask

   task automatic check_frame(input logic [79:0] exp);
      check("frame_len", 80'(tx_log.size()), 80'd10);
      for (int i = 0; i < 10 && i < tx_log.size(); i++) begin
         check($sformatf("tx_byte%0d", i), 80'(tx_log[i]), 80'(exp[79-8*i -: 8]));
      end
   endtask

   task automatic send_reply(input logic [63:0] r, input bit fin_start);
      for (int i = 0; i < 7; i++) send_rx(r[63-8*i -: 8]);
      iRXD_DATA  = r[7:0];
      iRXD_Ready = 1'b1;
      @(negedge iCLK);
      iRXD_Ready = 1'b0;
      check("done_pulse", 80'(oDONE), 80'd1);
      check("busy_low_at_done", 80'(oBUSY), 80'd0);
      check("reply_data", 80'(oDATA), 80'(r));
      if (fin_start) iSTART = 1'b1;
      @(negedge iCLK);
      iSTART = 1'b0;
      check("done_one_cycle", 80'(oDONE), 80'd0);
      check("busy_after_done", 80'(oBUSY), 80'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      // Reset state
      repeat (3) @(negedge iCLK);
      check("rst_busy",      80'(oBUSY),      80'd0);
      check("rst_done",      80'(oDONE),      80'd0);
      check("rst_timeout",   80'(oTIMEOUT),   80'd0);
      check("rst_data",      80'(oDATA),      80'd0);
      check("rst_txd_data",  80'(oTXD_DATA),  80'd0);
      check("rst_txd_start", 80'(oTXD_Start), 80'd0);
      iRST_n = 1'b1;
      @(negedge iCLK);

      // Frame with RX noise and a stray iSTART during TX, iSTART in FIN
      pulse_start(8'h02, 64'h0123456789ABCDEF);
      check("busy_after_start", 80'(oBUSY), 80'd1);
      send_rx(8'hAA);
      send_rx(8'hAA);
      pulse_start(8'h55, 64'hFFFF_0000_FFFF_0000);
      wait_tx(10);
      repeat (2) @(negedge iCLK);
      check_frame(80'h01_02_0123456789ABCDEF);
      send_reply(64'hFEDCBA9876543210, 1'b1);
      repeat (30) @(negedge iCLK);
      check("no_second_frame", 80'(tx_log.size()), 80'd10);
      check("one_done", 80'(done_cnt), 80'd1);
      check("idle_after_fin", 80'(oBUSY), 80'd0);

      // Timeout after 5 of 8 reply bytes
      tx_log.delete();
      pulse_start(8'h03, 64'h1122334455667788);
      wait_tx(10);
      repeat (2) @(negedge iCLK);
      check_frame(80'h01_03_1122334455667788);
      for (int i = 0; i < 5; i++) send_rx(8'h10 + 8'(i));
      repeat (98) @(negedge iCLK);
      check("timeout_not_early", 80'(oTIMEOUT), 80'd0);
      check("busy_before_timeout", 80'(oBUSY), 80'd1);
      @(negedge iCLK);
      check("timeout_pulse", 80'(oTIMEOUT), 80'd1);
      check("busy_at_timeout", 80'(oBUSY), 80'd0);
      check("data_kept", 80'(oDATA), 80'h0000_FEDCBA9876543210);
      check("no_done_on_timeout", 80'(oDONE), 80'd0);
      @(negedge iCLK);
      check("timeout_one_cycle", 80'(oTIMEOUT), 80'd0);
      check("one_timeout", 80'(tout_cnt), 80'd1);

      tx_log.delete();
      pulse_start(8'h04, 64'hA5A5_5A5A_0F0F_F0F0);
      check("restart_accepted", 80'(oBUSY), 80'd1);
      wait_tx(10);
      repeat (2) @(negedge iCLK);
      check_frame(80'h01_04_A5A55A5A0F0FF0F0);
      send_reply(64'h0F1E2D3C4B5A6978, 1'b0);
      check("two_done", 80'(done_cnt), 80'd2);

      // Reset in the middle of the frame
      tx_log.delete();
      pulse_start(8'h07, 64'h8899AABBCCDDEEFF);
      wait_tx(4);
      iRST_n = 1'b0;
      #1;
      check("midrst_busy",  80'(oBUSY),      80'd0);
      check("midrst_start", 80'(oTXD_Start), 80'd0);
      check("midrst_txd",   80'(oTXD_DATA),  80'd0);
      check("midrst_data",  80'(oDATA),      80'd0);
      check("midrst_done",  80'(oDONE),      80'd0);
      repeat (2) @(negedge iCLK);
      iRST_n = 1'b1;
      repeat (6) @(negedge iCLK);
      tx_log.delete();
      pulse_start(8'h09, 64'h0011223344556677);
      wait_tx(10);
      repeat (2) @(negedge iCLK);
      check_frame(80'h01_09_0011223344556677);
      send_reply(64'h13579BDF2468ACE0, 1'b0);
      check("three_done", 80'(done_cnt), 80'd3);
      check("no_pulse_from_reset", 80'(tout_cnt), 80'd1);
      check("start_never_while_busy", 80'(start_while_busy), 80'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
